bcd_tick_counter: RTL and testbench

Upstream stage of the 7-segment display path. It divides the board clock into a periodic tick and advances a two-digit BCD count (ones/tens) on each tick. The count runs up or down, wraps at a programmable modulus, and can be paused by a debounced push-button. Each digit output drives one 7-segment decoder instance directly.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/bcd_tick_counter.sv | 116 +++++++++++
 tb/tb_bcd_tick_counter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared BCD digit and 7-segment constants for the display path
package seg7_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  localparam int SEG_W = 7;
  // Active-high segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  function automatic logic [SEG_W-1:0] seg7_encode(input logic [DIGIT_W-1:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, stability filter and press detector
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/bcd_tick_counter.sv
// rtl/bcd_tick_counter.sv - prescaled two-digit BCD up/down counter with pause button
module bcd_tick_counter
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int WRAP       = 99,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up_dn,
  input  logic               clr,
  input  logic               btn_pause,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic               tick,
  output logic               wrap,
  output logic               running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [DIGIT_W-1:0] WRAP_TENS = DIGIT_W'(WRAP / 10);
  localparam logic [DIGIT_W-1:0] WRAP_ONES = DIGIT_W'(WRAP % 10);

  logic [PW-1:0]      pre_q, pre_d;
  logic [DIGIT_W-1:0] ones_q, ones_d, tens_q, tens_d;
  logic               tick_q, tick_d, wrap_q, wrap_d, running_q, running_d;
  logic               term, at_wrap, at_zero;
  logic               btn_level, btn_rise;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_pause),
    .level (btn_level),
    .rise  (btn_rise)
  );

  assign term    = en && (pre_q == PW'(DIV - 1));
  assign at_wrap = (tens_q == WRAP_TENS) && (ones_q == WRAP_ONES);
  assign at_zero = (tens_q == '0) && (ones_q == '0);

  always_comb begin
    pre_d = pre_q;
    if (clr || term) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + 1'b1;
    end
  end

  // clr outranks a step; the step itself sees the run flag from before this edge.
  always_comb begin
    ones_d    = ones_q;
    tens_d    = tens_q;
    tick_d    = term && !clr;
    wrap_d    = 1'b0;
    running_d = running_q ^ (btn_rise & btn_level);
    if (clr) begin
      ones_d = '0;
      tens_d = '0;
    end else if (term && running_q) begin
      if (up_dn) begin
        if (at_wrap) begin
          ones_d = '0;
          tens_d = '0;
          wrap_d = 1'b1;
        end else if (ones_q == DIGIT_MAX) begin
          ones_d = '0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          ones_d = WRAP_ONES;
          tens_d = WRAP_TENS;
          wrap_d = 1'b1;
        end else if (ones_q == '0) begin
          ones_d = DIGIT_MAX;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b1;
    end else begin
      pre_q     <= pre_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign ones    = ones_q;
  assign tens    = tens_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb/tb_bcd_tick_counter.sv - directed bench for bcd_tick_counter with WRAP=59 and WRAP=99
module tb_bcd_tick_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, clr, btn_pause;
  logic [3:0] ones59, tens59, ones99, tens99;
  logic       tick59, wrap59, running59, tick99, wrap99, running99;
  int         errors = 0;
  int         checks = 0;
  int         n;

  always #5 clk = ~clk;

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .WRAP(59), .DEB_CYCLES(4)) u_dut59 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .btn_pause(btn_pause),
    .ones(ones59), .tens(tens59), .tick(tick59), .wrap(wrap59), .running(running59)
  );

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .WRAP(99), .DEB_CYCLES(4)) u_dut99 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .btn_pause(btn_pause),
    .ones(ones99), .tens(tens99), .tick(tick99), .wrap(wrap99), .running(running99)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick59 && cycles < 200);
    if (!tick59) check("tick_timeout", tick59, 1);
  endtask

  task automatic wait_ticks(input int k);
    int c;
    for (int i = 0; i < k; i++) wait_tick(c);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; clr = 1'b0; btn_pause = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", {tens59, ones59}, 8'h00);
    check("rst_tick", tick59, 0);
    check("rst_wrap", wrap59, 0);
    check("rst_running", running59, 1);

    rst = 1'b0;
    wait_tick(n);
    check("first_tick_latency", n, 10);
    check("first_count", {tens59, ones59}, 8'h01);
    wait_ticks(8);
    check("count_09", {tens59, ones59}, 8'h09);
    wait_tick(n);
    check("tick_period", n, 10);
    check("count_10", {tens59, ones59}, 8'h10);
    wait_ticks(48);
    check("count_58", {tens59, ones59}, 8'h58);
    wait_tick(n);
    check("count_59", {tens59, ones59}, 8'h59);
    check("no_wrap_at_59", wrap59, 0);
    wait_tick(n);
    check("up_wrap_count", {tens59, ones59}, 8'h00);
    check("up_wrap_pulse", wrap59, 1);
    @(negedge clk);
    check("up_wrap_one_cycle", wrap59, 0);
    check("w99_count_60", {tens99, ones99}, 8'h60);
    wait_ticks(39);
    check("w99_count_99", {tens99, ones99}, 8'h99);
    wait_tick(n);
    check("w99_up_wrap_count", {tens99, ones99}, 8'h00);
    check("w99_up_wrap_pulse", wrap99, 1);
    check("w59_count_40", {tens59, ones59}, 8'h40);
    check("w59_no_wrap", wrap59, 0);

    up_dn = 1'b0;
    wait_tick(n);
    check("w99_down_wrap_count", {tens99, ones99}, 8'h99);
    check("w99_down_wrap_pulse", wrap99, 1);
    check("down_39", {tens59, ones59}, 8'h39);
    wait_ticks(29);
    check("down_10", {tens59, ones59}, 8'h10);
    wait_tick(n);
    check("down_09", {tens59, ones59}, 8'h09);
    wait_ticks(8);
    check("down_01", {tens59, ones59}, 8'h01);
    wait_tick(n);
    check("down_00", {tens59, ones59}, 8'h00);
    check("down_00_no_wrap", wrap59, 0);
    wait_tick(n);
    check("down_wrap_count", {tens59, ones59}, 8'h59);
    check("down_wrap_pulse", wrap59, 1);

    btn_pause = 1'b1;
    @(negedge clk);
    btn_pause = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_ignored", running59, 1);
    wait_tick(n);
    check("run_after_glitch", {tens59, ones59}, 8'h58);
    btn_pause = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (running59 && n < 7);
    check("pause_within_7", running59, 0);
    wait_tick(n);
    check("paused_tick", tick59, 1);
    check("paused_hold", {tens59, ones59}, 8'h58);
    check("paused_no_wrap", wrap59, 0);
    wait_tick(n);
    check("paused_hold2", {tens59, ones59}, 8'h58);
    btn_pause = 1'b0;
    repeat (9) @(negedge clk);
    check("release_no_toggle", running59, 0);
    wait_tick(n);
    btn_pause = 1'b1;
    repeat (8) @(negedge clk);
    check("resume_running", running59, 1);
    wait_tick(n);
    check("resume_count", {tens59, ones59}, 8'h57);
    btn_pause = 1'b0;

    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_count", {tens59, ones59}, 8'h00);
    check("clr_running", running59, 1);
    wait_tick(n);
    check("clr_restarts_period", n, 10);
    check("after_clr_down_wrap", {tens59, ones59}, 8'h59);

    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("prio_count", {tens59, ones59}, 8'h00);
    check("prio_tick", tick59, 0);
    check("prio_wrap", wrap59, 0);
    wait_tick(n);
    check("prio_next_tick", n, 10);
    check("prio_next_count", {tens59, ones59}, 8'h59);

    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (25) @(negedge clk);
    check("en_hold_no_tick", tick59, 0);
    en = 1'b1;
    wait_tick(n);
    check("en_delay_25", n, 7);
    check("en_count", {tens59, ones59}, 8'h58);

    btn_pause = 1'b1;
    repeat (8) @(negedge clk);
    check("pause_before_rst", running59, 0);
    btn_pause = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", {tens59, ones59}, 8'h00);
    check("async_rst_running", running59, 1);
    check("async_rst_tick", tick59, 0);
    check("async_rst_wrap", wrap59, 0);
    @(negedge clk);
    up_dn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_tick(n);
    check("post_rst_latency", n, 10);
    check("post_rst_count", {tens59, ones59}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
